br_sched: RTL and testbench

BR_SCHED -- requirements
Module: br_sched

---
 rtl/br_sched_pkg.sv | 26 ++
 rtl/br_age_sel.sv | 52 +++++
 rtl/br_sched.sv | 203 ++++++++++++++++++++
 tb/tb_br_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_sched_pkg.sv
// Shared system defines for the branch scheduler: widths, the SD delay macro,
// and the scheduler entry record.
`ifndef SD
`define SD
`endif

package br_sched_pkg;

  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int XLEN      = 64;
  localparam int INST_W    = 32;

  // One branch scheduler slot. rob_idx carries the wrap bit in its MSB.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      npc;
    logic [INST_W-1:0]    inst;
    logic [PRF_IDX_W-1:0] dest_tag;
    logic [ROB_IDX_W:0]   rob_idx;
    logic [PRF_IDX_W-1:0] opa_tag;
    logic                 opa_rdy;
    logic [XLEN-1:0]      opa_val;
  } br_ent_t;

endpackage

// File: rtl/br_age_sel.sv
// Age logic for the branch scheduler: flags entries younger than a recovery
// point and picks the oldest surviving requester. Purely combinational.
module br_age_sel
  import br_sched_pkg::*;
#(
  parameter  int NUM_ENT = 4,
  localparam int IDX_W   = $clog2(NUM_ENT)
) (
  input  logic [NUM_ENT-1:0] req_i,
  input  logic [ROB_IDX_W:0] rob_idx_i [NUM_ENT],
  input  logic               rec_valid_i,
  input  logic [ROB_IDX_W:0] rec_rob_idx_i,
  input  logic [ROB_IDX_W:0] cand_rob_idx_i,
  output logic [NUM_ENT-1:0] squash_o,
  output logic               cand_squash_o,
  output logic               sel_vld_o,
  output logic [IDX_W-1:0]   sel_idx_o
);

  // a is older than b; a differing wrap bit means the lower index wrapped past b.
  function automatic logic older(input logic [ROB_IDX_W:0] a,
                                 input logic [ROB_IDX_W:0] b);
    if (a[ROB_IDX_W] == b[ROB_IDX_W])
      return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
    else
      return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
  endfunction

  // Mark stored entries and the incoming dispatch that are strictly younger than the recovery point.
  always_comb begin
    squash_o = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      squash_o[i] = rec_valid_i && older(rec_rob_idx_i, rob_idx_i[i]);
    end
    cand_squash_o = rec_valid_i && older(rec_rob_idx_i, cand_rob_idx_i);
  end

  // Linear scan for the oldest requester that survives recovery.
  always_comb begin
    sel_vld_o = 1'b0;
    sel_idx_o = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (req_i[i] && !squash_o[i]) begin
        if (!sel_vld_o || older(rob_idx_i[i], rob_idx_i[sel_idx_o])) begin
          sel_vld_o = 1'b1;
          sel_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/br_sched.sv
// Branch reservation station: holds dispatched branches until regA is ready,
// wakes them from the CDB, and issues the oldest ready one per cycle into a
// registered bundle for the branch FU. Recovery squashes younger work.
module br_sched
  import br_sched_pkg::*;
#(
  parameter  int NUM_ENT = 4,
  localparam int IDX_W   = $clog2(NUM_ENT),
  localparam int CNT_W   = $clog2(NUM_ENT) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_en_i,
  input  logic [XLEN-1:0]      disp_npc_i,
  input  logic [INST_W-1:0]    disp_inst_i,
  input  logic [PRF_IDX_W-1:0] disp_dest_tag_i,
  input  logic [ROB_IDX_W:0]   disp_rob_idx_i,
  input  logic [PRF_IDX_W-1:0] disp_opa_tag_i,
  input  logic                 disp_opa_rdy_i,
  input  logic [XLEN-1:0]      disp_opa_val_i,
  input  logic                 cdb_valid_i,
  input  logic [PRF_IDX_W-1:0] cdb_tag_i,
  input  logic [XLEN-1:0]      cdb_val_i,
  input  logic                 rec_valid_i,
  input  logic [ROB_IDX_W:0]   rec_rob_idx_i,
  output logic                 full_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 iss_start_o,
  output logic [XLEN-1:0]      iss_npc_o,
  output logic [XLEN-1:0]      iss_opa_o,
  output logic [INST_W-1:0]    iss_inst_o,
  output logic [PRF_IDX_W-1:0] iss_dest_tag_o,
  output logic [ROB_IDX_W:0]   iss_rob_idx_o
);

  br_ent_t              ent_q [NUM_ENT];
  br_ent_t              ent_d [NUM_ENT];
  br_ent_t              new_ent;
  logic [NUM_ENT-1:0]   valid_vec;
  logic [NUM_ENT-1:0]   rdy_vec;
  logic [ROB_IDX_W:0]   ent_rob [NUM_ENT];
  logic [NUM_ENT-1:0]   squash;
  logic                 cand_squash;
  logic                 sel_vld;
  logic [IDX_W-1:0]     sel_idx;
  logic                 free_vld;
  logic [IDX_W-1:0]     free_idx;
  logic                 disp_ok;
  logic                 full;
  logic [CNT_W-1:0]     cnt;

  logic                 iss_start_q, iss_start_d;
  logic [XLEN-1:0]      iss_npc_q, iss_npc_d;
  logic [XLEN-1:0]      iss_opa_q, iss_opa_d;
  logic [INST_W-1:0]    iss_inst_q, iss_inst_d;
  logic [PRF_IDX_W-1:0] iss_dest_tag_q, iss_dest_tag_d;
  logic [ROB_IDX_W:0]   iss_rob_idx_q, iss_rob_idx_d;

  // Flatten registered entry state into vectors for the age selector and occupancy.
  always_comb begin
    valid_vec = '0;
    rdy_vec   = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      valid_vec[i] = ent_q[i].valid;
      rdy_vec[i]   = ent_q[i].valid && ent_q[i].opa_rdy;
      ent_rob[i]   = ent_q[i].rob_idx;
    end
  end

  // Occupancy comes from registered valid bits only, so a same-edge issue does not relieve full.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      cnt = cnt + CNT_W'(valid_vec[i]);
    end
    full = &valid_vec;
  end

  // Lowest-numbered free slot; scanning downward leaves the smallest index last.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  br_age_sel #(.NUM_ENT(NUM_ENT)) u_age_sel (
    .req_i          (rdy_vec),
    .rob_idx_i      (ent_rob),
    .rec_valid_i    (rec_valid_i),
    .rec_rob_idx_i  (rec_rob_idx_i),
    .cand_rob_idx_i (disp_rob_idx_i),
    .squash_o       (squash),
    .cand_squash_o  (cand_squash),
    .sel_vld_o      (sel_vld),
    .sel_idx_o      (sel_idx)
  );

  // Build the incoming entry, catching a same-cycle CDB broadcast for a waiting operand.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.npc      = disp_npc_i;
    new_ent.inst     = disp_inst_i;
    new_ent.dest_tag = disp_dest_tag_i;
    new_ent.rob_idx  = disp_rob_idx_i;
    new_ent.opa_tag  = disp_opa_tag_i;
    new_ent.opa_rdy  = disp_opa_rdy_i;
    new_ent.opa_val  = disp_opa_val_i;
    if (!disp_opa_rdy_i && cdb_valid_i && (cdb_tag_i == disp_opa_tag_i)) begin
      new_ent.opa_rdy = 1'b1;
      new_ent.opa_val = cdb_val_i;
    end
    // A dispatch while full is dropped so stored entries stay intact.
    disp_ok = disp_en_i && free_vld && !cand_squash;
  end

  // Next entry state: wakeup, free the issued slot, squash younger, then write the dispatch.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (ent_q[i].valid && !ent_q[i].opa_rdy && cdb_valid_i &&
          (cdb_tag_i == ent_q[i].opa_tag)) begin
        ent_d[i].opa_rdy = 1'b1;
        ent_d[i].opa_val = cdb_val_i;
      end
    end
    if (sel_vld) begin
      ent_d[sel_idx].valid = 1'b0;
    end
    for (int i = 0; i < NUM_ENT; i++) begin
      if (squash[i]) begin
        ent_d[i].valid = 1'b0;
      end
    end
    if (disp_ok) begin
      ent_d[free_idx] = new_ent;
    end
  end

  // Issue register loads the selected bundle; data holds when nothing is selected.
  always_comb begin
    iss_start_d    = sel_vld;
    iss_npc_d      = iss_npc_q;
    iss_opa_d      = iss_opa_q;
    iss_inst_d     = iss_inst_q;
    iss_dest_tag_d = iss_dest_tag_q;
    iss_rob_idx_d  = iss_rob_idx_q;
    if (sel_vld) begin
      iss_npc_d      = ent_q[sel_idx].npc;
      iss_opa_d      = ent_q[sel_idx].opa_val;
      iss_inst_d     = ent_q[sel_idx].inst;
      iss_dest_tag_d = ent_q[sel_idx].dest_tag;
      iss_rob_idx_d  = ent_q[sel_idx].rob_idx;
    end
  end

  // State registers with synchronous reset clearing entries and the issue bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i] <= `SD '0;
      end
      iss_start_q    <= `SD 1'b0;
      iss_npc_q      <= `SD '0;
      iss_opa_q      <= `SD '0;
      iss_inst_q     <= `SD '0;
      iss_dest_tag_q <= `SD '0;
      iss_rob_idx_q  <= `SD '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i] <= `SD ent_d[i];
      end
      iss_start_q    <= `SD iss_start_d;
      iss_npc_q      <= `SD iss_npc_d;
      iss_opa_q      <= `SD iss_opa_d;
      iss_inst_q     <= `SD iss_inst_d;
      iss_dest_tag_q <= `SD iss_dest_tag_d;
      iss_rob_idx_q  <= `SD iss_rob_idx_d;
    end
  end

  // Dispatching into a full station is an upstream bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(disp_en_i && full));
    end
  end

  assign full_o         = full;
  assign cnt_o          = cnt;
  assign iss_start_o    = iss_start_q;
  assign iss_npc_o      = iss_npc_q;
  assign iss_opa_o      = iss_opa_q;
  assign iss_inst_o     = iss_inst_q;
  assign iss_dest_tag_o = iss_dest_tag_q;
  assign iss_rob_idx_o  = iss_rob_idx_q;

endmodule

// File: tb/tb_br_sched.sv
// Directed bench for br_sched: issue latency, CDB wakeup, age order across the
// wrap bit, full/count behaviour, recovery squash and mid-run reset.
module tb_br_sched;
  import br_sched_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 disp_en_i;
  logic [XLEN-1:0]      disp_npc_i;
  logic [INST_W-1:0]    disp_inst_i;
  logic [PRF_IDX_W-1:0] disp_dest_tag_i;
  logic [ROB_IDX_W:0]   disp_rob_idx_i;
  logic [PRF_IDX_W-1:0] disp_opa_tag_i;
  logic                 disp_opa_rdy_i;
  logic [XLEN-1:0]      disp_opa_val_i;
  logic                 cdb_valid_i;
  logic [PRF_IDX_W-1:0] cdb_tag_i;
  logic [XLEN-1:0]      cdb_val_i;
  logic                 rec_valid_i;
  logic [ROB_IDX_W:0]   rec_rob_idx_i;
  logic                 full_o;
  logic [2:0]           cnt_o;
  logic                 iss_start_o;
  logic [XLEN-1:0]      iss_npc_o;
  logic [XLEN-1:0]      iss_opa_o;
  logic [INST_W-1:0]    iss_inst_o;
  logic [PRF_IDX_W-1:0] iss_dest_tag_o;
  logic [ROB_IDX_W:0]   iss_rob_idx_o;

  int checks = 0;
  int errors = 0;

  br_sched #(.NUM_ENT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .disp_en_i       (disp_en_i),
    .disp_npc_i      (disp_npc_i),
    .disp_inst_i     (disp_inst_i),
    .disp_dest_tag_i (disp_dest_tag_i),
    .disp_rob_idx_i  (disp_rob_idx_i),
    .disp_opa_tag_i  (disp_opa_tag_i),
    .disp_opa_rdy_i  (disp_opa_rdy_i),
    .disp_opa_val_i  (disp_opa_val_i),
    .cdb_valid_i     (cdb_valid_i),
    .cdb_tag_i       (cdb_tag_i),
    .cdb_val_i       (cdb_val_i),
    .rec_valid_i     (rec_valid_i),
    .rec_rob_idx_i   (rec_rob_idx_i),
    .full_o          (full_o),
    .cnt_o           (cnt_o),
    .iss_start_o     (iss_start_o),
    .iss_npc_o       (iss_npc_o),
    .iss_opa_o       (iss_opa_o),
    .iss_inst_o      (iss_inst_o),
    .iss_dest_tag_o  (iss_dest_tag_o),
    .iss_rob_idx_o   (iss_rob_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_en_i       = 1'b0;
    disp_npc_i      = '0;
    disp_inst_i     = '0;
    disp_dest_tag_i = '0;
    disp_rob_idx_i  = '0;
    disp_opa_tag_i  = '0;
    disp_opa_rdy_i  = 1'b0;
    disp_opa_val_i  = '0;
    cdb_valid_i     = 1'b0;
    cdb_tag_i       = '0;
    cdb_val_i       = '0;
    rec_valid_i     = 1'b0;
    rec_rob_idx_i   = '0;
  endtask

  // npc = 0x1000 + rob, inst = rob, dest tag = rob so the bundle is traceable.
  task automatic disp(input logic [5:0] rob, input logic [5:0] tag,
                      input logic rdy, input logic [63:0] val);
    disp_en_i       = 1'b1;
    disp_rob_idx_i  = rob;
    disp_npc_i      = 64'h1000 + {58'h0, rob};
    disp_inst_i     = {26'h0, rob};
    disp_dest_tag_i = rob;
    disp_opa_tag_i  = tag;
    disp_opa_rdy_i  = rdy;
    disp_opa_val_i  = val;
  endtask

  task automatic wake(input logic [5:0] tag, input logic [63:0] val);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = tag;
    cdb_val_i   = val;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cnt", 64'(cnt_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_start", 64'(iss_start_o), 64'd0);
    chk("rst_rob", 64'(iss_rob_idx_o), 64'd0);
    chk("rst_opa", iss_opa_o, 64'd0);
    chk("rst_npc", iss_npc_o, 64'd0);
    rst = 1'b0;

    // Ready dispatch issues two cycles later.
    disp(6'd5, 6'd0, 1'b1, 64'd0);
    tick();
    disp_en_i = 1'b0;
    chk("lat_cnt_n1", 64'(cnt_o), 64'd1);
    chk("lat_start_n1", 64'(iss_start_o), 64'd0);
    tick();
    chk("lat_start_n2", 64'(iss_start_o), 64'd1);
    chk("lat_rob", 64'(iss_rob_idx_o), 64'd5);
    chk("lat_opa", iss_opa_o, 64'd0);
    chk("lat_npc", iss_npc_o, 64'h1005);
    chk("lat_dest", 64'(iss_dest_tag_o), 64'd5);
    chk("lat_inst", 64'(iss_inst_o), 64'd5);
    chk("lat_cnt_n2", 64'(cnt_o), 64'd0);
    tick();
    chk("lat_start_drop", 64'(iss_start_o), 64'd0);
    chk("lat_rob_hold", 64'(iss_rob_idx_o), 64'd5);

    // Two waiters on tag 12; older rob 6 sits in the higher slot.
    disp(6'd7, 6'd12, 1'b0, 64'd0);
    tick();
    disp(6'd6, 6'd12, 1'b0, 64'd0);
    tick();
    disp_en_i = 1'b0;
    chk("wk_cnt", 64'(cnt_o), 64'd2);
    tick();
    chk("wk_no_issue", 64'(iss_start_o), 64'd0);
    wake(6'd12, 64'h40);
    tick();
    cdb_valid_i = 1'b0;
    chk("wk_start_n1", 64'(iss_start_o), 64'd0);
    tick();
    chk("wk_first_start", 64'(iss_start_o), 64'd1);
    chk("wk_first_rob", 64'(iss_rob_idx_o), 64'd6);
    chk("wk_first_opa", iss_opa_o, 64'h40);
    tick();
    chk("wk_second_start", 64'(iss_start_o), 64'd1);
    chk("wk_second_rob", 64'(iss_rob_idx_o), 64'd7);
    chk("wk_second_opa", iss_opa_o, 64'h40);
    tick();
    chk("wk_idle_start", 64'(iss_start_o), 64'd0);
    chk("wk_idle_cnt", 64'(cnt_o), 64'd0);

    // Dispatch catches a CDB broadcast in the same cycle.
    disp(6'd8, 6'd20, 1'b0, 64'd0);
    wake(6'd20, 64'h55);
    tick();
    disp_en_i   = 1'b0;
    cdb_valid_i = 1'b0;
    tick();
    chk("sc_start", 64'(iss_start_o), 64'd1);
    chk("sc_rob", 64'(iss_rob_idx_o), 64'd8);
    chk("sc_opa", iss_opa_o, 64'h55);
    tick();

    // Wrap: rob 0x21 (wrap 1, low 1) is younger than 0x1E (wrap 0, low 30).
    disp(6'h21, 6'd5, 1'b0, 64'd0);
    tick();
    disp(6'h1E, 6'd5, 1'b0, 64'd0);
    tick();
    disp_en_i = 1'b0;
    wake(6'd5, 64'h77);
    tick();
    cdb_valid_i = 1'b0;
    tick();
    chk("wrap_first", 64'(iss_rob_idx_o), 64'h1E);
    tick();
    chk("wrap_second", 64'(iss_rob_idx_o), 64'h21);
    chk("wrap_second_start", 64'(iss_start_o), 64'd1);
    tick();

    // Fill all four slots, then drain.
    for (int k = 0; k < 4; k++) begin
      disp(6'h10 + 6'(k), 6'd30, 1'b0, 64'd0);
      tick();
    end
    disp_en_i = 1'b0;
    chk("full_set", 64'(full_o), 64'd1);
    chk("full_cnt", 64'(cnt_o), 64'd4);
    wake(6'd30, 64'd3);
    tick();
    cdb_valid_i = 1'b0;
    chk("full_hold_sel", 64'(full_o), 64'd1);
    chk("full_hold_cnt", 64'(cnt_o), 64'd4);
    tick();
    chk("full_clear", 64'(full_o), 64'd0);
    chk("full_cnt3", 64'(cnt_o), 64'd3);
    chk("full_iss_rob", 64'(iss_rob_idx_o), 64'h10);
    tick();
    tick();
    tick();
    chk("drain_last_rob", 64'(iss_rob_idx_o), 64'h13);
    chk("drain_last_start", 64'(iss_start_o), 64'd1);
    chk("drain_cnt", 64'(cnt_o), 64'd0);
    tick();
    chk("drain_idle", 64'(iss_start_o), 64'd0);

    // Recovery at rob 3 squashes 4,5 and the same-cycle dispatch of 6.
    disp(6'd3, 6'd40, 1'b0, 64'd0);
    tick();
    disp(6'd4, 6'd40, 1'b0, 64'd0);
    tick();
    disp(6'd5, 6'd40, 1'b0, 64'd0);
    tick();
    disp(6'd6, 6'd0, 1'b1, 64'd0);
    rec_valid_i   = 1'b1;
    rec_rob_idx_i = 6'd3;
    tick();
    disp_en_i   = 1'b0;
    rec_valid_i = 1'b0;
    chk("rec_cnt", 64'(cnt_o), 64'd1);
    wake(6'd40, 64'h99);
    tick();
    cdb_valid_i = 1'b0;
    tick();
    chk("rec_survivor_start", 64'(iss_start_o), 64'd1);
    chk("rec_survivor_rob", 64'(iss_rob_idx_o), 64'd3);
    chk("rec_survivor_opa", iss_opa_o, 64'h99);
    tick();
    chk("rec_no_more", 64'(iss_start_o), 64'd0);
    chk("rec_cnt0", 64'(cnt_o), 64'd0);

    // A ready entry squashed in the cycle it would be selected never issues.
    disp(6'h0A, 6'd41, 1'b0, 64'd0);
    tick();
    disp(6'h0C, 6'd0, 1'b1, 64'h0C);
    tick();
    disp_en_i     = 1'b0;
    rec_valid_i   = 1'b1;
    rec_rob_idx_i = 6'h0A;
    tick();
    rec_valid_i = 1'b0;
    chk("rec_excl_start", 64'(iss_start_o), 64'd0);
    chk("rec_excl_cnt", 64'(cnt_o), 64'd1);

    // Reset with three valid entries and a loaded issue register.
    disp(6'h0E, 6'd50, 1'b0, 64'd0);
    tick();
    disp(6'h0F, 6'd50, 1'b0, 64'd0);
    tick();
    disp(6'h11, 6'd0, 1'b1, 64'h11);
    tick();
    disp_en_i = 1'b0;
    chk("pre_rst_cnt", 64'(cnt_o), 64'd4);
    tick();
    chk("pre_rst_start", 64'(iss_start_o), 64'd1);
    chk("pre_rst_rob", 64'(iss_rob_idx_o), 64'h11);
    chk("pre_rst_cnt3", 64'(cnt_o), 64'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_start", 64'(iss_start_o), 64'd0);
    chk("mid_rst_cnt", 64'(cnt_o), 64'd0);
    chk("mid_rst_full", 64'(full_o), 64'd0);
    chk("mid_rst_rob", 64'(iss_rob_idx_o), 64'd0);
    rst = 1'b0;
    wake(6'd50, 64'h1);
    tick();
    wake(6'd41, 64'h2);
    tick();
    cdb_valid_i = 1'b0;
    tick();
    chk("post_rst_start", 64'(iss_start_o), 64'd0);
    chk("post_rst_cnt", 64'(cnt_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
